// File: rtl/alu_mcyc_pkg.sv
// Shared opcode definitions for the multi-cycle ALU and its divider.
package common;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBB = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NAND = 4'd6,
    OP_XOR  = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_LHB  = 4'd11,
    OP_MUL  = 4'd12,
    OP_DIV  = 4'd13,
    OP_DIVU = 4'd14
  } alu_op_t;

  function automatic logic is_div_op(alu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_mcyc_divider.sv
// Restoring divider: one quotient bit per cycle on operand magnitudes,
// signs and the divide-by-zero / overflow cases resolved on the outputs.
module alu_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, src_q, src_d;
  logic             q_neg_q, q_neg_d, r_neg_q, r_neg_d;
  logic             dz_q, dz_d, mno_q, mno_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic             s_dd, s_dv;

  always_comb begin
    s_dd    = is_signed & dividend[WIDTH-1];
    s_dv    = is_signed & divisor[WIDTH-1];
    shifted = {rem_q, quo_q[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - dvs_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    src_d   = src_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    mno_d   = mno_q;
    if (start) begin
      cnt_d   = CW'(WIDTH);
      quo_d   = s_dd ? -dividend : dividend;
      dvs_d   = s_dv ? -divisor : divisor;
      rem_d   = '0;
      src_d   = dividend;
      q_neg_d = s_dd ^ s_dv;
      r_neg_d = s_dd;
      dz_d    = (divisor == '0);
      mno_d   = is_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (divisor == '1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      // partial remainder stays below the divisor, so diff fits in WIDTH bits
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = diff;
        quo_d = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      src_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      mno_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      src_q   <= src_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      mno_q   <= mno_d;
    end
  end

  always_comb begin
    done      = (cnt_q == CW'(1));
    quotient  = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
    remainder = dz_q ? src_q : (r_neg_q ? -rem_q : rem_q);
    ovf       = dz_q | mno_q;
  end

endmodule

// File: rtl/alu_mcyc.sv
// Multi-cycle ALU with registered result, multiply-high/remainder and PSW.
// Iterative DIV/DIVU and their FSM exist only when ALU_MCYC_DIV_EN is defined.
module alu_mcyc
  import common::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  alu_op_t          func,
  input  logic [SHW-1:0]   shamt,
  input  logic             valid_in,
  input  logic             update_all,
  input  logic             update_nz,
  input  logic             stall_EX_DM,
  output logic [WIDTH-1:0] dst_EX_DM,
  output logic [WIDTH-1:0] MULH_EX_DM,
  output logic [3:0]       PSW_EX_DM,
  output logic             busy
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0]   dst_q, dst_d, mulh_q, mulh_d;
  logic [3:0]         psw_q, psw_d;
  logic [WIDTH-1:0]   add_b, sh, alu_res, alu_mulh, wr_res, wr_mulh;
  logic [WIDTH:0]     sum;
  logic               add_cin, add_ov;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [3:0]         alu_psw, wr_psw;
  logic               wr_en, wr_mulh_en, wr_all, wr_nz;

  always_comb begin
    add_b = (func == OP_SUB || func == OP_SUBB) ? ~src0 : src0;
    case (func)
      OP_ADDC, OP_SUBB: add_cin = psw_q[3];
      OP_SUB:           add_cin = 1'b1;
      default:          add_cin = 1'b0;
    endcase
    sum    = {1'b0, src1} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_ov = (src1[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);

    sh = src1;
    for (int i = 0; i < SHW; i++) begin
      if (shamt[i]) begin
        if (func == OP_SLL)      sh = sh << (1 << i);
        else if (func == OP_SRA) sh = $signed(sh) >>> (1 << i);
        else                     sh = sh >> (1 << i);
      end
    end

    // shamt[0] selects a signed multiply via sign-extension to full width
    mul_a = {{WIDTH{shamt[0] & src1[WIDTH-1]}}, src1};
    mul_b = {{WIDTH{shamt[0] & src0[WIDTH-1]}}, src0};
    prod  = mul_a * mul_b;

    case (func)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBB: alu_res = sum[WIDTH-1:0];
      OP_AND:                           alu_res = src1 & src0;
      OP_OR:                            alu_res = src1 | src0;
      OP_NAND:                          alu_res = ~(src1 & src0);
      OP_XOR:                           alu_res = src1 ^ src0;
      OP_SLL, OP_SRL, OP_SRA:           alu_res = sh;
      OP_LHB:                           alu_res = {src1[HW-1:0], src0[HW-1:0]};
      OP_MUL:                           alu_res = prod[WIDTH-1:0];
      default:                          alu_res = '0;
    endcase
    alu_mulh = prod[2*WIDTH-1:WIDTH];
    alu_psw  = is_div_op(func) ? 4'b0101
                               : {sum[WIDTH], add_ov, alu_res[WIDTH-1], alu_res == '0};
  end

`ifdef ALU_MCYC_DIV_EN
  // state    | meaning
  // S_IDLE   | accepting ops; single-cycle ops execute here
  // S_DIVIDE | divider producing one quotient bit per cycle
  // S_FIXUP  | signed result ready; written once downstream is not stalled
  typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_FIXUP} state_t;

  state_t           state_q, state_d;
  logic             div_start, div_done, div_wr, div_ovf, sc_wr;
  logic [WIDTH-1:0] div_quo, div_rem;
  logic             upd_all_q, upd_all_d, upd_nz_q, upd_nz_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (valid_in && is_div_op(func)) state_d = S_DIVIDE;
      S_DIVIDE: if (div_done) state_d = S_FIXUP;
      S_FIXUP:  if (!stall_EX_DM) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    div_start = (state_q == S_IDLE) && valid_in && is_div_op(func);
    div_wr    = (state_q == S_FIXUP) && !stall_EX_DM;
  end

  // PSW selects belong to the divide instruction, so capture them at launch
  always_comb begin
    upd_all_d = div_start ? update_all : upd_all_q;
    upd_nz_d  = div_start ? update_nz  : upd_nz_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_all_q <= 1'b0;
      upd_nz_q  <= 1'b0;
    end else begin
      upd_all_q <= upd_all_d;
      upd_nz_q  <= upd_nz_d;
    end
  end

  alu_divider #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .is_signed (func == OP_DIV),
    .dividend  (src1),
    .divisor   (src0),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem),
    .ovf       (div_ovf)
  );

  always_comb begin
    sc_wr      = valid_in && !busy && !stall_EX_DM && !is_div_op(func);
    wr_en      = sc_wr || div_wr;
    wr_mulh_en = div_wr || (sc_wr && func == OP_MUL);
    wr_res     = div_wr ? div_quo : alu_res;
    wr_mulh    = div_wr ? div_rem : alu_mulh;
    wr_psw     = div_wr ? {1'b0, div_ovf, div_quo[WIDTH-1], div_quo == '0} : alu_psw;
    wr_all     = div_wr ? upd_all_q : update_all;
    wr_nz      = div_wr ? upd_nz_q  : update_nz;
  end
`else
  always_comb begin
    busy       = 1'b0;
    wr_en      = valid_in && !stall_EX_DM;
    wr_mulh_en = valid_in && !stall_EX_DM && (func == OP_MUL);
    wr_res     = alu_res;
    wr_mulh    = alu_mulh;
    wr_psw     = alu_psw;
    wr_all     = update_all;
    wr_nz      = update_nz;
  end
`endif

  always_comb begin
    dst_d  = dst_q;
    mulh_d = mulh_q;
    psw_d  = psw_q;
    if (wr_en) begin
      dst_d = wr_res;
      if (wr_mulh_en) mulh_d = wr_mulh;
      if (wr_all)     psw_d = wr_psw;
      else if (wr_nz) psw_d[1:0] = wr_psw[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q  <= '0;
      mulh_q <= '0;
      psw_q  <= '0;
    end else begin
      dst_q  <= dst_d;
      mulh_q <= mulh_d;
      psw_q  <= psw_d;
    end
  end

  assign dst_EX_DM  = dst_q;
  assign MULH_EX_DM = mulh_q;
  assign PSW_EX_DM  = psw_q;

endmodule
